// File: rtl/ring_router_mux_pkg.sv
// Shared types for the ring router output merge: the DII flit and the arbiter state encoding.
package ring_router_mux_pkg;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RING  = 2'd1,
    LOCAL = 2'd2
  } state_t;

  // Counter width able to hold 0..burst inclusive.
  function automatic int cnt_width(input int burst);
    return (burst < 1) ? 1 : $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/ring_router_mux_if.sv
// One flit link with valid/ready handshake; master drives the flit, slave drives ready.
interface ring_router_mux_if;
  import ring_router_mux_pkg::*;

  dii_flit flit;
  logic    ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);

endinterface

// File: rtl/ring_router_mux_arb.sv
// Packet-atomic arbiter: worm locking and bounded starvation of local injection.
//
// state | meaning
// IDLE  | no packet in flight, grant decided from head-flit valids
// RING  | ring worm locked until its last flit is accepted
// LOCAL | local worm locked until its last flit is accepted
module ring_router_mux_arb
  import ring_router_mux_pkg::*;
#(
  parameter int RING_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ring_valid,
  input  logic ring_last,
  input  logic local_valid,
  input  logic local_last,
  input  logic load_ok,
  output logic grant_ring,
  output logic grant_local
);

  localparam int CNT_W = cnt_width(RING_BURST);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(RING_BURST);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             acc_ring, acc_local;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    grant_ring  = 1'b0;
    grant_local = 1'b0;
    acc_ring    = 1'b0;
    acc_local   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ring_valid && !(local_valid && (starve_q >= BURST_MAX))) grant_ring = 1'b1;
        else if (local_valid)                                        grant_local = 1'b1;
      end
      RING:    grant_ring  = 1'b1;
      LOCAL:   grant_local = 1'b1;
      default: state_d     = IDLE;
    endcase

    acc_ring  = grant_ring  & ring_valid  & load_ok;
    acc_local = grant_local & local_valid & load_ok;

    // Starvation bookkeeping only moves on packet heads, i.e. accepts taken in IDLE.
    if (state_q == IDLE) begin
      if (acc_ring) begin
        if (local_valid && (starve_q < BURST_MAX)) starve_d = starve_q + 1'b1;
        if (!ring_last) state_d = RING;
      end
      if (acc_local) begin
        starve_d = '0;
        if (!local_last) state_d = LOCAL;
      end
    end else if ((acc_ring && ring_last) || (acc_local && local_last)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ring_router_mux.sv
// Merges ring pass-through and local injection onto the outgoing ring link
// through a single registered output stage.
module ring_router_mux
  import ring_router_mux_pkg::*;
#(
  parameter int RING_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  ring_router_mux_if.slave   in_ring,
  ring_router_mux_if.slave   in_local,
  ring_router_mux_if.master  out_ring
);

  dii_flit out_q, out_d;
  logic    load_ok;
  logic    grant_ring, grant_local;
  logic    acc_ring, acc_local;

  ring_router_mux_arb #(.RING_BURST(RING_BURST)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .ring_valid  (in_ring.flit.valid),
    .ring_last   (in_ring.flit.last),
    .local_valid (in_local.flit.valid),
    .local_last  (in_local.flit.last),
    .load_ok     (load_ok),
    .grant_ring  (grant_ring),
    .grant_local (grant_local)
  );

  always_comb begin
    load_ok        = !out_q.valid || out_ring.ready;
    in_ring.ready  = grant_ring  && load_ok && !rst;
    in_local.ready = grant_local && load_ok && !rst;
    acc_ring       = in_ring.ready  && in_ring.flit.valid;
    acc_local      = in_local.ready && in_local.flit.valid;

    out_d = out_q;
    if (load_ok) begin
      out_d.valid = 1'b0;
      if (acc_ring)       out_d = in_ring.flit;
      else if (acc_local) out_d = in_local.flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out_ring.flit = out_q;

endmodule

// File: tb/tb_ring_router_mux.sv
// Bench for ring_router_mux: cycle table, packet-order scoreboard and reset-mid-worm sequence.
module tb_ring_router_mux;
  import ring_router_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ring_router_mux_if in_ring ();
  ring_router_mux_if in_local ();
  ring_router_mux_if out_ring ();

  ring_router_mux #(.RING_BURST(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_ring  (in_ring),
    .in_local (in_local),
    .out_ring (out_ring)
  );

  typedef struct {
    logic        rv; logic [15:0] rd; logic rl;
    logic        lv; logic [15:0] ld; logic ll;
    logic        ordy;
    logic        exp_rr, exp_lr, exp_ov;
    logic [15:0] exp_od;
    logic        exp_ol;
    state_t      exp_st;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        is_local;
  } sb_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  sb_t  src_ring[$], src_local[$], exp_q[$];
  int   out_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [15:0] rd, input logic rl,
                              input logic lv, input logic [15:0] ld, input logic ll,
                              input logic ordy, input logic err, input logic elr,
                              input logic eov, input logic [15:0] eod, input logic eol,
                              input state_t est);
    vec_t v;
    v = '{rv, rd, rl, lv, ld, ll, ordy, err, elr, eov, eod, eol, est};
    return v;
  endfunction

  task automatic drive_idle();
    in_ring.flit  = '0;
    in_local.flit = '0;
    out_ring.ready = 1'b1;
  endtask

  // Called at a falling edge; samples just before the next rising edge.
  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    in_ring.flit   = '{data: v.rd, last: v.rl, valid: v.rv};
    in_local.flit  = '{data: v.ld, last: v.ll, valid: v.lv};
    out_ring.ready = v.ordy;
    #3;
    chk({tag, "_ring_ready"},  32'(in_ring.ready),  32'(v.exp_rr));
    chk({tag, "_local_ready"}, 32'(in_local.ready), 32'(v.exp_lr));
    chk({tag, "_out_valid"},   32'(out_ring.flit.valid), 32'(v.exp_ov));
    if (v.exp_ov) begin
      chk({tag, "_out_data"}, 32'(out_ring.flit.data), 32'(v.exp_od));
      chk({tag, "_out_last"}, 32'(out_ring.flit.last), 32'(v.exp_ol));
    end
    chk({tag, "_state"}, 32'(u_dut.u_arb.state_q), 32'(v.exp_st));
    @(negedge clk);
  endtask

  task automatic run_sb(input string name, input int local_start);
    int   cyc;
    logic fire_r, fire_l;
    sb_t  e;
    cyc = 0;
    out_cyc.delete();
    while (exp_q.size() != 0 && cyc < 200) begin
      if (src_ring.size() != 0)
        in_ring.flit = '{data: src_ring[0].data, last: src_ring[0].last, valid: 1'b1};
      else
        in_ring.flit = '0;
      if (src_local.size() != 0 && cyc >= local_start)
        in_local.flit = '{data: src_local[0].data, last: src_local[0].last, valid: 1'b1};
      else
        in_local.flit = '0;
      out_ring.ready = 1'b1;
      #3;
      fire_r = in_ring.flit.valid  && in_ring.ready;
      fire_l = in_local.flit.valid && in_local.ready;
      chk({name, "_one_ready"}, 32'(in_ring.ready && in_local.ready), 32'd0);
      if (out_ring.flit.valid) begin
        e = exp_q.pop_front();
        out_cyc.push_back(cyc);
        chk({name, "_out_data"}, 32'(out_ring.flit.data), 32'(e.data));
        chk({name, "_out_last"}, 32'(out_ring.flit.last), 32'(e.last));
        if (e.is_local) chk({name, "_starve_after_local"}, 32'(u_dut.u_arb.starve_q), 32'd0);
      end
      @(negedge clk);
      if (fire_r) void'(src_ring.pop_front());
      if (fire_l) void'(src_local.pop_front());
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: %0d flits still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
    drive_idle();
    #3;
    chk({name, "_drained"}, 32'(out_ring.flit.valid), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string ord;
    int    ri, li;

    // Reset with a ring flit already offered: ready must stay low.
    rst = 1'b1;
    drive_idle();
    in_ring.flit = '{data: 16'hDEAD, last: 1'b1, valid: 1'b1};
    repeat (2) @(negedge clk);
    #3;
    chk("rst_ring_ready", 32'(in_ring.ready), 32'd0);
    chk("rst_out_valid",  32'(out_ring.flit.valid), 32'd0);
    chk("rst_state",      32'(u_dut.u_arb.state_q), 32'(IDLE));
    chk("rst_starve",     32'(u_dut.u_arb.starve_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();

    //            rv  rd        rl   lv  ld        ll   rdy  rr lr ov  od        ol   st
    vecs.push_back(mk(1, 16'h0005, 0,  0, 16'h0000, 0,  1,  1, 0, 0, 16'h0000, 0, IDLE));
    vecs.push_back(mk(1, 16'hAAAA, 0,  0, 16'h0000, 0,  1,  1, 0, 1, 16'h0005, 0, RING));
    vecs.push_back(mk(1, 16'hBBBB, 1,  0, 16'h0000, 0,  1,  1, 0, 1, 16'hAAAA, 0, RING));
    vecs.push_back(mk(0, 16'h0000, 0,  0, 16'h0000, 0,  1,  0, 0, 1, 16'hBBBB, 1, IDLE));
    vecs.push_back(mk(0, 16'h0000, 0,  0, 16'h0000, 0,  1,  0, 0, 0, 16'h0000, 0, IDLE));
    vecs.push_back(mk(0, 16'h0000, 0,  1, 16'h1001, 0,  1,  0, 1, 0, 16'h0000, 0, IDLE));
    vecs.push_back(mk(0, 16'h0000, 0,  1, 16'h1002, 0,  0,  0, 0, 1, 16'h1001, 0, LOCAL));
    vecs.push_back(mk(0, 16'h0000, 0,  1, 16'h1002, 0,  0,  0, 0, 1, 16'h1001, 0, LOCAL));
    vecs.push_back(mk(0, 16'h0000, 0,  1, 16'h1002, 0,  1,  0, 1, 1, 16'h1001, 0, LOCAL));
    vecs.push_back(mk(0, 16'h0000, 0,  1, 16'h1003, 0,  1,  0, 1, 1, 16'h1002, 0, LOCAL));
    vecs.push_back(mk(0, 16'h0000, 0,  1, 16'h1004, 1,  1,  0, 1, 1, 16'h1003, 0, LOCAL));
    vecs.push_back(mk(0, 16'h0000, 0,  0, 16'h0000, 0,  1,  0, 0, 1, 16'h1004, 1, IDLE));
    vecs.push_back(mk(1, 16'h2001, 1,  0, 16'h0000, 0,  1,  1, 0, 0, 16'h0000, 0, IDLE));
    vecs.push_back(mk(1, 16'h2002, 1,  1, 16'h1101, 1,  0,  0, 0, 1, 16'h2001, 1, IDLE));
    vecs.push_back(mk(1, 16'h2002, 1,  1, 16'h1101, 1,  1,  1, 0, 1, 16'h2001, 1, IDLE));
    vecs.push_back(mk(0, 16'h0000, 0,  1, 16'h1101, 1,  1,  0, 1, 1, 16'h2002, 1, IDLE));
    vecs.push_back(mk(0, 16'h0000, 0,  0, 16'h0000, 0,  1,  0, 0, 1, 16'h1101, 1, IDLE));
    vecs.push_back(mk(0, 16'h0000, 0,  0, 16'h0000, 0,  1,  0, 0, 0, 16'h0000, 0, IDLE));
    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);
    drive_idle();

    // Local packet arrives while a 4-flit ring worm is in progress.
    for (int i = 0; i < 4; i++) begin
      src_ring.push_back('{16'h4000 + 16'(i), (i == 3), 1'b0});
      exp_q.push_back('{16'h4000 + 16'(i), (i == 3), 1'b0});
    end
    for (int i = 0; i < 2; i++) begin
      src_local.push_back('{16'h5000 + 16'(i), (i == 1), 1'b1});
      exp_q.push_back('{16'h5000 + 16'(i), (i == 1), 1'b1});
    end
    run_sb("midworm", 2);
    if (out_cyc.size() >= 5) chk("midworm_local_gap", 32'(out_cyc[4] - out_cyc[3]), 32'd1);

    // Both inputs saturated with single-flit packets.
    ord = "RRRRLRRRRLRRL";
    ri = 0;
    li = 0;
    for (int i = 0; i < 10; i++) src_ring.push_back('{16'h6000 + 16'(i), 1'b1, 1'b0});
    for (int i = 0; i < 3; i++)  src_local.push_back('{16'h7000 + 16'(i), 1'b1, 1'b1});
    for (int i = 0; i < ord.len(); i++) begin
      if (ord[i] == "R") begin
        exp_q.push_back('{16'h6000 + 16'(ri), 1'b1, 1'b0});
        ri++;
      end else begin
        exp_q.push_back('{16'h7000 + 16'(li), 1'b1, 1'b1});
        li++;
      end
    end
    run_sb("burst", 0);

    // Reset during flit 2 of a ring worm, with local waiting so starve_cnt is non-zero.
    in_ring.flit  = '{data: 16'h8000, last: 1'b0, valid: 1'b1};
    in_local.flit = '{data: 16'h9000, last: 1'b0, valid: 1'b1};
    #3;
    chk("rw_head_ring_ready", 32'(in_ring.ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    in_ring.flit = '{data: 16'h8001, last: 1'b0, valid: 1'b1};
    #3;
    chk("rw_pre_state",   32'(u_dut.u_arb.state_q), 32'(RING));
    chk("rw_pre_starve",  32'(u_dut.u_arb.starve_q), 32'd1);
    chk("rw_rst_ready",   32'(in_ring.ready || in_local.ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_ring.flit = '0;
    #3;
    chk("rw_out_valid",   32'(out_ring.flit.valid), 32'd0);
    chk("rw_state",       32'(u_dut.u_arb.state_q), 32'(IDLE));
    chk("rw_starve",      32'(u_dut.u_arb.starve_q), 32'd0);
    chk("rw_local_ready", 32'(in_local.ready), 32'd1);
    @(negedge clk);
    in_local.flit = '{data: 16'h9001, last: 1'b1, valid: 1'b1};
    #3;
    chk("rw_l0_data",     32'(out_ring.flit.data), 32'h9000);
    chk("rw_l1_ready",    32'(in_local.ready), 32'd1);
    @(negedge clk);
    drive_idle();
    #3;
    chk("rw_l1_data",     32'(out_ring.flit.data), 32'h9001);
    chk("rw_l1_last",     32'(out_ring.flit.last), 32'd1);
    chk("rw_end_state",   32'(u_dut.u_arb.state_q), 32'(IDLE));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
